// File: rtl/neuron_fetch_ctrl_pkg.sv
// Shared types for the neuron synapse fetch sequencer.
// State encodings, the default address width and enable levels.
package neuron_fetch_ctrl_pkg;

    localparam int FC_ADDR_WIDTH = 8;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_ISSUE = 2'd1,
        FC_DRAIN = 2'd2,
        FC_DONE  = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fc_addr_gen.sv
// Base-load / increment address counter.
// Wraps modulo 2^W; used for both addresses and the beat count.
module fc_addr_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] base,
    output logic [W-1:0] addr
);

    logic [W-1:0] addr_d;
    logic [W-1:0] addr_q;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = base;
        end else if (inc) begin
            addr_d = addr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/neuron_fetch_ctrl.sv
// Synapse fetch sequencer: issues N weight/input reads and flags
// the returned beats one cycle later for the DataFetch register stage.
module neuron_fetch_ctrl
    import neuron_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] num_syn,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] i_base,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  sel_rdy,
    output logic                  sel_last,
    output logic                  busy,
    output logic                  done
);

    fc_state_e state_d;
    fc_state_e state_q;

    logic [ADDR_WIDTH-1:0] n_d;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  load;
    logic                  last;
    logic                  sel_rdy_d;
    logic                  sel_rdy_q;
    logic                  sel_last_d;
    logic                  sel_last_q;

    assign load = (state_q == FC_IDLE) & start & ~abort
                & (num_syn != '0);
    assign last = (cnt == n_q - ADDR_WIDTH'(1));

    fc_addr_gen #(.W(ADDR_WIDTH)) u_w_addr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .inc   (rd_en),
        .base  (w_base),
        .addr  (w_addr)
    );

    fc_addr_gen #(.W(ADDR_WIDTH)) u_i_addr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .inc   (rd_en),
        .base  (i_base),
        .addr  (i_addr)
    );

    fc_addr_gen #(.W(ADDR_WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .inc   (rd_en),
        .base  ('0),
        .addr  (cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = FC_IDLE;
        end else begin
            unique case (state_q)
                FC_IDLE: begin
                    if (start) begin
                        state_d = (num_syn == '0) ? FC_DONE : FC_ISSUE;
                    end
                end
                FC_ISSUE: begin
                    if (rd_en && last) begin
                        state_d = FC_DRAIN;
                    end
                end
                FC_DRAIN: state_d = FC_DONE;
                FC_DONE:  state_d = FC_IDLE;
                default:  state_d = FC_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en = DISABLE;
        if (state_q == FC_ISSUE && !stall && !abort) begin
            rd_en = ENABLE;
        end
        busy = (state_q != FC_IDLE);
        // An abort landing on the DONE cycle suppresses the pulse.
        done = (state_q == FC_DONE) & ~abort;
    end

    always_comb begin
        n_d        = load ? num_syn : n_q;
        sel_rdy_d  = rd_en;
        sel_last_d = rd_en & last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q        <= '0;
            sel_rdy_q  <= DISABLE;
            sel_last_q <= DISABLE;
        end else begin
            n_q        <= n_d;
            sel_rdy_q  <= sel_rdy_d;
            sel_last_q <= sel_last_d;
        end
    end

    assign sel_rdy  = sel_rdy_q;
    assign sel_last = sel_last_q;

endmodule

// File: tb/tb_neuron_fetch_ctrl.sv
// Self-checking bench for neuron_fetch_ctrl against a
// schedule-based model of issue, return and completion timing.
module tb_neuron_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       stall;
    logic [7:0] num_syn;
    logic [7:0] w_base;
    logic [7:0] i_base;
    logic       rd_en;
    logic [7:0] w_addr;
    logic [7:0] i_addr;
    logic       sel_rdy;
    logic       sel_last;
    logic       busy;
    logic       done;

    int n_err = 0;
    int n_chk = 0;

    bit stall_v[256];

    neuron_fetch_ctrl #(.ADDR_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .stall    (stall),
        .num_syn  (num_syn),
        .w_base   (w_base),
        .i_base   (i_base),
        .rd_en    (rd_en),
        .w_addr   (w_addr),
        .i_addr   (i_addr),
        .sel_rdy  (sel_rdy),
        .sel_last (sel_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".rd_en"}, 32'(rd_en), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".sel_rdy"}, 32'(sel_rdy), 0);
        chk({tag, ".sel_last"}, 32'(sel_last), 0);
    endtask

    task automatic clear_stall();
        for (int k = 0; k < 256; k++) stall_v[k] = 1'b0;
    endtask

    // abort_c: 0 = none, -1 = random, else cycle index after accept
    task automatic run_seq(input string tag, input int n,
                           input logic [7:0] wb, input logic [7:0] ib,
                           input int abort_req, input bit noise);
        int issue_c[$];
        bit rd_x[256];
        int idx_x[256];
        int c;
        int done_c;
        int end_c;
        int abort_c;
        bit done_x;
        for (int k = 0; k < 256; k++) begin
            rd_x[k]  = 1'b0;
            idx_x[k] = 0;
        end
        c = 1;
        while (issue_c.size() < n) begin
            if (!stall_v[c] || c > 100) issue_c.push_back(c);
            c++;
        end
        done_c = (n == 0) ? 1 : issue_c[n-1] + 2;
        abort_c = abort_req;
        if (abort_req < 0) begin
            abort_c = ($urandom_range(0, 3) == 0)
                    ? int'($urandom_range(1, done_c + 1)) : 0;
        end
        end_c = done_c;
        if (abort_c > 0 && abort_c < end_c) end_c = abort_c;
        done_x = (abort_c == 0) || (done_c < abort_c);
        foreach (issue_c[j]) begin
            if (abort_c == 0 || issue_c[j] < abort_c) begin
                rd_x[issue_c[j]]  = 1'b1;
                idx_x[issue_c[j]] = j;
            end
        end

        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b0;
        stall   = 1'($urandom);
        num_syn = 8'(n);
        w_base  = wb;
        i_base  = ib;
        #1;
        chk({tag, ".accept.busy"}, 32'(busy), 0);
        chk({tag, ".accept.rd_en"}, 32'(rd_en), 0);

        for (int cc = 1; cc <= end_c + 2; cc++) begin
            @(negedge clk);
            abort = (cc == abort_c);
            stall = (cc <= 100) ? stall_v[cc] : 1'b0;
            if (noise && cc <= end_c) begin
                start   = 1'($urandom);
                num_syn = 8'($urandom);
                w_base  = 8'($urandom);
                i_base  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            chk({tag, ".rd_en"}, 32'(rd_en), 32'(rd_x[cc]));
            chk({tag, ".sel_rdy"}, 32'(sel_rdy), 32'(rd_x[cc-1]));
            chk({tag, ".sel_last"}, 32'(sel_last),
                32'(rd_x[cc-1] && idx_x[cc-1] == n - 1));
            chk({tag, ".done"}, 32'(done),
                32'(cc == done_c && done_x));
            chk({tag, ".busy"}, 32'(busy), 32'(cc <= end_c));
            if (rd_x[cc]) begin
                chk({tag, ".w_addr"}, 32'(w_addr), 32'(8'(wb + idx_x[cc])));
                chk({tag, ".i_addr"}, 32'(i_addr), 32'(8'(ib + idx_x[cc])));
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        stall   = 1'b0;
        num_syn = 8'd5;
        w_base  = 8'h33;
        i_base  = 8'h44;
        clear_stall();

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_quiet("reset");
            chk("reset.w_addr", 32'(w_addr), 0);
            chk("reset.i_addr", 32'(i_addr), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk_quiet("idle");
        end

        run_seq("basic", 4, 8'h10, 8'h40, 0, 1'b0);

        clear_stall();
        stall_v[2] = 1'b1;
        stall_v[3] = 1'b1;
        run_seq("wrap", 3, 8'hFE, 8'hFF, 0, 1'b0);
        clear_stall();

        run_seq("zero", 0, 8'h21, 8'h22, 0, 1'b0);
        run_seq("abort", 6, 8'h80, 8'h90, 3, 1'b0);
        run_seq("after_abort", 2, 8'h05, 8'h06, 0, 1'b0);
        run_seq("busy_start", 5, 8'hA0, 8'hB0, 0, 1'b1);

        // async reset mid-sequence acts immediately, not at an edge
        @(negedge clk);
        start   = 1'b1;
        num_syn = 8'd8;
        w_base  = 8'h70;
        i_base  = 8'h71;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_reset.pre.rd_en", 32'(rd_en), 1);
        #1;
        reset = 1'b0;
        #1;
        chk_quiet("mid_reset");
        chk("mid_reset.w_addr", 32'(w_addr), 0);
        chk("mid_reset.i_addr", 32'(i_addr), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 256; k++)
                stall_v[k] = ($urandom_range(0, 9) < 3);
            run_seq("rand", int'($urandom_range(0, 12)), 8'($urandom),
                    8'($urandom), -1, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/neuron_fetch_ctrl.md
Name: neuron_fetch_ctrl

Overview:
- Sequencer for one neuron's synapse fetch.
- On `start`, issues N consecutive read addresses to the weight and input memories, both of which have a fixed 1-cycle read latency.
- Drives `sel_rdy`, aligned with the returned data, into the DataFetch register stage. Flags the last beat and pulses `done` when the fetch sequence completes.
- Sits between the neuron top-level control and the df_reg/MAC datapath.

Parameters:
- ADDR_WIDTH, 8, width of weight/input addresses and of the synapse count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a fetch sequence; sampled only in IDLE.
- abort  input  1  cancel the current sequence; return to IDLE.
- stall  input  1  downstream back-pressure; blocks new address issue only.
- num_syn  input  ADDR_WIDTH  synapse count N; sampled on accepted start.
- w_base  input  ADDR_WIDTH  weight memory base address; sampled on accepted start.
- i_base  input  ADDR_WIDTH  input memory base address; sampled on accepted start.
- rd_en  output  1  memory read strobe (combinational: state==ISSUE & ~stall & ~abort).
- w_addr  output  ADDR_WIDTH  weight read address (registered).
- i_addr  output  ADDR_WIDTH  input read address (registered).
- sel_rdy  output  1  data-valid to df_reg; registered copy of rd_en.
- sel_last  output  1  high with the sel_rdy of beat N-1.
- busy  output  1  high in ISSUE, DRAIN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - w_addr = i_addr = 0; beat counter = 0; latched N = 0.
  - sel_rdy = sel_last = done = busy = 0; rd_en = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and num_syn!=0: latch N, load w_addr<=w_base, i_addr<=i_base, cnt<=0, go to ISSUE.
  - start=1 and num_syn==0: go directly to DONE. No rd_en and no sel_rdy occur.
  - start=0: stay in IDLE.
- ISSUE:
  - rd_en=1 when stall=0.
  - Each issue cycle: w_addr, i_addr and cnt each increment by 1. Addresses wrap modulo 2^ADDR_WIDTH, with no error.
  - An issue with cnt==N-1 is the last beat; go to DRAIN.
  - stall=1: hold addresses, cnt and state; rd_en=0.
- Register stage (every cycle):
  - sel_rdy <= rd_en.
  - sel_last <= rd_en & (cnt==N-1).
  - Read data returned in cycle t+1 is therefore accompanied by sel_rdy=1 in cycle t+1.
- DRAIN: one cycle, during which the final sel_rdy/sel_last are visible; then go to DONE. stall is ignored in DRAIN.
- DONE: done=1 for exactly one cycle; then go to IDLE.
- Latency with no stalls:
  - start accepted at clock edge k.
  - rd_en high in cycles k+1 .. k+N.
  - sel_rdy high in cycles k+2 .. k+N+1; sel_last in cycle k+N+1.
  - done in cycle k+N+2.
  - Each stall cycle in ISSUE adds exactly one cycle to every later event.
- start while busy=1: ignored. No re-latch of num_syn/bases.
- abort=1 (any state, priority over start and stall):
  - Next state is IDLE.
  - rd_en is forced 0 in the same cycle.
  - sel_rdy/sel_last are cleared at the next edge, so an in-flight beat is dropped.
  - No done pulse.
  - w_addr, i_addr and cnt hold their current values.
- Downstream contract: stall only blocks new issues. The consumer must absorb the single beat already in flight.
- The async reset mid-sequence has the same effect as power-up reset and takes effect immediately.

Decomposition:
- Shared package/header (alongside stddef.h): state encodings FC_IDLE/FC_ISSUE/FC_DRAIN/FC_DONE (2-bit) and `ENABLE/`DISABLE; reuse the existing data-width defines.
- One natural sub-module: fc_addr_gen. It holds one base-load/increment/wrap address counter and is instantiated twice (weight, input); cnt uses the same counter form.
- FSM and sel_rdy/sel_last registers stay in the top.

Test Plan:
- Reset then idle: reset low for 3 cycles → all outputs 0; after release with start=0 for 10 cycles, busy/rd_en stay 0.
- Basic fetch, N=4, w_base=8'h10, i_base=8'h40, stall=0:
  - rd_en high 4 cycles with w_addr 10,11,12,13 and i_addr 40,41,42,43.
  - sel_rdy high 4 cycles starting 1 cycle after the first rd_en; sel_last only on the 4th.
  - done exactly 1 cycle after the last sel_rdy.
- Stall and wrap, N=3, w_base=8'hFE, stall=1 during the 2nd issue cycle for 2 cycles:
  - w_addr sequence FE, FF, 00, with address held during stall.
  - sel_rdy shows a 2-cycle gap; done arrives 2 cycles later than without stall.
- Zero length, num_syn=0: start → done one cycle after the start edge; rd_en/sel_rdy never high.
- Abort after 2 of N=6 issues → rd_en drops the same cycle, sel_rdy clears the next cycle, no done, busy=0. A new start with N=2 then completes normally.
- Start while busy: a second start with different num_syn/bases mid-sequence → ignored; the original N=5 sequence completes unchanged.
